// File: rtl/cla_serial_sub.sv
// Serial subtractor: a - b as a + ~b + 1, one nibble per clock on a single 4-bit CLA slice.
// Optional output saturation on signed overflow is enabled by defining CLA_SUB_SAT_EN.
module cla_serial_sub #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow,
   output logic             o_ovf,
   output logic             o_zero
);

   localparam int unsigned N     = WIDTH / 4;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(N - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic              carry_q, carry_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
   logic              ready_q, ready_d, valid_q, valid_d;

   logic              load_c, step_c, last_c;
   logic [3:0]        nib_a_c, nib_b_c, p_c, g_c, sum_c;
   logic [4:0]        c_c;
   logic [WIDTH-1:0]  diff_raw_c, diff_fin_c;
   logic              ovf_c;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_valid) state_d = RUN;
         RUN:     if (cnt_q == LAST_NIB) state_d = DONE;
         DONE:    if (i_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control strobes decoded from the state
   always_comb begin
      load_c = 1'b0;
      step_c = 1'b0;
      last_c = 1'b0;
      case (state_q)
         IDLE: load_c = i_valid;
         RUN: begin
            step_c = 1'b1;
            last_c = (cnt_q == LAST_NIB);
         end
         default: ;
      endcase
   end

   // 4-bit carry-lookahead slice; operands shift right so the active nibble is always [3:0]
   always_comb begin
      nib_a_c = a_q[3:0];
      nib_b_c = ~b_q[3:0];
      p_c     = nib_a_c ^ nib_b_c;
      g_c     = nib_a_c & nib_b_c;
      c_c[0]  = carry_q;
      c_c[1]  = g_c[0] | (p_c[0] & c_c[0]);
      c_c[2]  = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & c_c[0]);
      c_c[3]  = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
              | (p_c[2] & p_c[1] & p_c[0] & c_c[0]);
      c_c[4]  = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
              | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
              | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & c_c[0]);
      sum_c   = p_c ^ c_c[3:0];
   end

   // On the last nibble a_q[3]/b_q[3] hold the original operand sign bits
   always_comb begin
      diff_raw_c = {sum_c, diff_q[WIDTH-1:4]};
      ovf_c      = (a_q[3] != b_q[3]) & (sum_c[3] != a_q[3]);
`ifdef CLA_SUB_SAT_EN
      if (ovf_c) diff_fin_c = a_q[3] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else       diff_fin_c = diff_raw_c;
`else
      diff_fin_c = diff_raw_c;
`endif
   end

   // Datapath next-state
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      if (load_c) begin
         a_d     = i_a;
         b_d     = i_b;
         carry_d = 1'b1;
         cnt_d   = '0;
      end
      if (step_c) begin
         a_d     = a_q >> 4;
         b_d     = b_q >> 4;
         carry_d = c_c[4];
         cnt_d   = cnt_q + CNT_W'(1);
         diff_d  = diff_raw_c;
         if (last_c) begin
            diff_d   = diff_fin_c;
            borrow_d = ~c_c[4];
            ovf_d    = ovf_c;
            zero_d   = (diff_raw_c == '0);
         end
      end
      ready_d = (state_d == IDLE);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
      end
   end

   assign o_ready  = ready_q;
   assign o_valid  = valid_q;
   assign o_diff   = diff_q;
   assign o_borrow = borrow_q;
   assign o_ovf    = ovf_q;
   assign o_zero   = zero_q;

endmodule

// File: tb/tb_cla_serial_sub.sv
// Bench for cla_serial_sub (WIDTH=16): directed vectors, reset abort and random ops
// checked against an arithmetic reference model.
module tb_cla_serial_sub;

   localparam int unsigned W = 16;

   logic          i_clk = 1'b0;
   logic          i_rst_n, i_valid, i_ready;
   logic [W-1:0]  i_a, i_b;
   logic          o_ready, o_valid, o_borrow, o_ovf, o_zero;
   logic [W-1:0]  o_diff;

   int checks = 0;
   int errors = 0;

   cla_serial_sub #(.WIDTH(W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
      .o_diff(o_diff), .o_borrow(o_borrow), .o_ovf(o_ovf), .o_zero(o_zero)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic bo, output logic ov,
                        output logic z);
      int sa, sb, r;
      logic [W-1:0] raw;
      sa  = $signed(a);
      sb  = $signed(b);
      r   = sa - sb;
      raw = a - b;
      ov  = (r > 32767) || (r < -32768);
      bo  = (a < b);
      z   = (raw == 16'h0000);
      d   = raw;
`ifdef CLA_SUB_SAT_EN
      if (ov) d = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input bit use_exp, input logic [W-1:0] ed, input logic ebo,
                         input logic eov, input logic ez);
      logic [W-1:0] md;
      logic mbo, mov, mz;
      int cyc;
      model(a, b, md, mbo, mov, mz);
      if (use_exp) begin
         md = ed; mbo = ebo; mov = eov; mz = ez;
      end
      @(negedge i_clk);
      chk("ready_idle", 32'(o_ready), 32'd1);
      i_a = a; i_b = b; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_a = 16'($urandom); i_b = 16'($urandom);
      chk("ready_busy", 32'(o_ready), 32'd0);
      cyc = 0;
      while (!o_valid && cyc < 20) begin
         @(posedge i_clk); #1;
         cyc++;
      end
      chk("latency", 32'(cyc), 32'd4);
      chk("diff", 32'(o_diff), 32'(md));
      chk("borrow", 32'(o_borrow), 32'(mbo));
      chk("ovf", 32'(o_ovf), 32'(mov));
      chk("zero", 32'(o_zero), 32'(mz));
      for (int h = 0; h < hold; h++) begin
         @(negedge i_clk);
         i_valid = 1'($urandom);
         chk("hold_valid", 32'(o_valid), 32'd1);
         chk("hold_ready", 32'(o_ready), 32'd0);
         chk("hold_diff", 32'(o_diff), 32'(md));
         chk("hold_flags", 32'({o_borrow, o_ovf, o_zero}), 32'({mbo, mov, mz}));
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      chk("valid_drop", 32'(o_valid), 32'd0);
      chk("ready_back", 32'(o_ready), 32'd1);
   endtask

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_diff", 32'(o_diff), 32'd0);
      chk("rst_flags", 32'({o_borrow, o_ovf, o_zero}), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      run_op(16'h1234, 16'h0234, 0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
      run_op(16'h0000, 16'h0001, 1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
`ifdef CLA_SUB_SAT_EN
      run_op(16'h8000, 16'h0001, 0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`else
      run_op(16'h8000, 16'h0001, 0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`endif
      run_op(16'hABCD, 16'hABCD, 10, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

      // Reset during RUN after nibble 1 aborts the op
      @(negedge i_clk);
      i_a = 16'h4321; i_b = 16'h1111; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      chk("abort_valid", 32'(o_valid), 32'd0);
      chk("abort_ready", 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      run_op(16'h0005, 16'h0003, 0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         case (n % 8)
            0: rb = ra;
            1: ra = 16'h8000 | ra;
            2: rb = 16'h8000 | rb;
            default: ;
         endcase
         run_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
